// File: rtl/wav_mcuintf_mbox.sv
// Host<->MCU mailbox: two {ID,DATA} message FIFOs behind a generic register port
// with level status, sticky overflow/underflow flags, flush and level IRQs.
module wav_mcuintf_mbox #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int IDW    = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     i_hclk,
  input  logic                     i_hreset,
  input  logic                     i_write,
  input  logic                     i_read,
  input  logic [AWIDTH-1:0]        i_addr,
  input  logic [DWIDTH-1:0]        i_wdata,
  output logic [DWIDTH-1:0]        o_rdata,
  output logic                     o_error,
  output logic                     o_ready,
  output logic                     o_h2m_irq,
  output logic                     o_m2h_irq,
  output logic [$clog2(DEPTH):0]   o_h2m_level,
  output logic [$clog2(DEPTH):0]   o_m2h_level
);

  localparam int LVLW = $clog2(DEPTH) + 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int EW   = IDW + DWIDTH;

  typedef enum logic {ST_IDLE, ST_RESP} state_t;
  state_t state, state_nxt;

  logic [EW-1:0]   mem [2][DEPTH];
  logic [PW-1:0]   wr_ptr [2];
  logic [PW-1:0]   rd_ptr [2];
  logic [LVLW-1:0] level [2];
  logic [IDW-1:0]  id_stage [2];
  logic [1:0]      ovf, udf, full, empty;
  logic [1:0]      irq_en;

  logic [4:0] word;
  logic       dir;
  logic [2:0] reg_off;
  logic       active;
  logic       do_push, do_pop, do_id_wr, do_flush, do_clr, do_irq_wr, set_ovf, set_udf;
  logic [EW-1:0] head;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[AWIDTH-1:7], i_addr[1:0]};

  assign word    = i_addr[6:2];
  assign dir     = word[3];
  assign reg_off = word[2:0];
  assign head    = mem[dir][rd_ptr[dir]];

  always_comb begin
    for (int unsigned d = 0; d < 2; d++) begin
      full[d]  = (level[d] == LVLW'(DEPTH));
      empty[d] = (level[d] == '0);
    end
  end

  assign o_h2m_level = level[0];
  assign o_m2h_level = level[1];
  assign o_h2m_irq   = ~empty[0] & irq_en[0];
  assign o_m2h_irq   = ~empty[1] & irq_en[1];

  always_ff @(posedge i_hclk) begin
    if (!i_hreset) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Request is still held during the response cycle, so the response state always returns to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_write || i_read) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Response and commit strobes are decoded from the held request during the response cycle.
  always_comb begin
    active    = (state == ST_RESP) && i_hreset;
    o_ready   = 1'b0;
    o_error   = 1'b0;
    o_rdata   = '0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_id_wr  = 1'b0;
    do_flush  = 1'b0;
    do_clr    = 1'b0;
    do_irq_wr = 1'b0;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    if (active) begin
      o_ready = 1'b1;
      if (word == 5'h10) begin
        if (i_write) do_irq_wr = 1'b1;
        else         o_rdata   = DWIDTH'(irq_en);
      end else if (word[4] || reg_off == 3'd7) begin
        o_error = 1'b1;
      end else begin
        case (reg_off)
          3'd0: if (i_write) do_id_wr = 1'b1;
                else         o_rdata  = DWIDTH'(id_stage[dir]);
          3'd1: if (!i_write)      o_error = 1'b1;
                else if (full[dir]) begin o_error = 1'b1; set_ovf = 1'b1; end
                else                do_push = 1'b1;
          3'd2: if (i_write)        o_error = 1'b1;
                else if (!empty[dir]) o_rdata = head[DWIDTH-1:0];
          3'd3: if (i_write)        o_error = 1'b1;
                else if (!empty[dir]) o_rdata = DWIDTH'(head[EW-1:DWIDTH]);
          3'd4: if (!i_write)       o_error = 1'b1;
                else if (empty[dir]) begin o_error = 1'b1; set_udf = 1'b1; end
                else                do_pop = 1'b1;
          3'd5: if (i_write) o_error = 1'b1;
                else o_rdata = DWIDTH'({udf[dir], ovf[dir], full[dir], empty[dir], level[dir]});
          3'd6: if (i_write) begin do_flush = i_wdata[0]; do_clr = i_wdata[1]; end
          default: o_error = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge i_hclk) begin
    if (!i_hreset) begin
      wr_ptr   <= '{default: '0};
      rd_ptr   <= '{default: '0};
      level    <= '{default: '0};
      id_stage <= '{default: '0};
      ovf      <= '0;
      udf      <= '0;
      irq_en   <= '0;
    end else begin
      if (do_id_wr) id_stage[dir] <= i_wdata[IDW-1:0];
      if (do_push) begin
        wr_ptr[dir] <= wr_ptr[dir] + PW'(1);
        level[dir]  <= level[dir] + LVLW'(1);
      end
      if (do_pop) begin
        rd_ptr[dir] <= rd_ptr[dir] + PW'(1);
        level[dir]  <= level[dir] - LVLW'(1);
      end
      if (set_ovf) ovf[dir] <= 1'b1;
      if (set_udf) udf[dir] <= 1'b1;
      if (do_flush) begin
        wr_ptr[dir] <= '0;
        rd_ptr[dir] <= '0;
        level[dir]  <= '0;
      end
      if (do_clr) begin
        ovf[dir] <= 1'b0;
        udf[dir] <= 1'b0;
      end
      if (do_irq_wr) irq_en <= i_wdata[1:0];
    end
  end

  always_ff @(posedge i_hclk) begin
    if (do_push) mem[dir][wr_ptr[dir]] <= {id_stage[dir], i_wdata};
  end

endmodule
